// File: rtl/mem_port_arbiter.sv
// N-master arbiter in front of the shared single-port data RAM.
// Per-access fixed-priority or round-robin arbitration, locked bursts, per-master read valid.
module mem_port_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int RR_MODE     = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            req,
    input  logic [NUM_MASTERS-1:0]            we,
    input  logic [NUM_MASTERS-1:0]            lock,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]     wdata,
    output logic [NUM_MASTERS-1:0]            gnt,
    output logic [NUM_MASTERS-1:0]            rvalid,
    output logic [DATA_W-1:0]                 rdata,
    output logic [$clog2(NUM_MASTERS)-1:0]    owner,
    output logic                              busy,
    output logic                              ram_we,
    output logic                              ram_re,
    output logic [ADDR_W-1:0]                 ram_addr,
    output logic [DATA_W-1:0]                 ram_wdata,
    input  logic [DATA_W-1:0]                 ram_rdata,
    input  logic                              ram_busy
);

    localparam int OW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDATA} state_t;

    state_t                  r_state, w_next;
    logic [OW-1:0]           r_owner, r_rr_ptr;
    logic [DATA_W-1:0]       r_rdata;
    logic [OW-1:0]           w_base, w_winner;
    logic [2*NUM_MASTERS-1:0] w_rot2;
    logic [NUM_MASTERS-1:0]  w_rot;
    logic                    w_found, w_done;
    int                      w_sum;

    logic [ADDR_W-1:0] w_addr  [NUM_MASTERS];
    logic [DATA_W-1:0] w_wdata [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_split
        assign w_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
    end

    // Rotate requests so the scan always starts at bit 0; fixed mode rotates by zero.
    assign w_base = (RR_MODE != 0) ? r_rr_ptr : '0;
    assign w_rot2 = {req, req} >> w_base;
    assign w_rot  = w_rot2[NUM_MASTERS-1:0];

    always_comb begin
        w_found = 1'b0;
        w_sum   = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = int'(w_base) + k;
            end
        end
        if (w_sum >= NUM_MASTERS) w_sum = w_sum - NUM_MASTERS;
        w_winner = w_sum[OW-1:0];
    end

    always_comb begin
        w_next    = r_state;
        w_done    = 1'b0;
        gnt       = '0;
        rvalid    = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        rdata     = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (|req) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                ram_addr  = w_addr[r_owner];
                ram_wdata = w_wdata[r_owner];
                if (!req[r_owner]) begin
                    w_next = S_IDLE;
                end else if (!ram_busy) begin
                    gnt[r_owner] = 1'b1;
                    ram_we       = we[r_owner];
                    ram_re       = ~we[r_owner];
                    if (we[r_owner]) w_done = 1'b1;
                    else             w_next = S_RDATA;
                end
            end
            S_RDATA: begin
                rdata           = ram_rdata;
                rvalid[r_owner] = 1'b1;
                w_done          = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
        // A locked owner still requesting keeps the port without re-arbitration.
        if (w_done) w_next = (lock[r_owner] && req[r_owner]) ? S_ISSUE : S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && |req) r_owner <= w_winner;
            if (r_state == S_RDATA) r_rdata <= ram_rdata;
            if (w_done && RR_MODE != 0)
                r_rr_ptr <= (r_owner == OW'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;
        end
    end

    assign owner = r_owner;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: 2-master fixed-priority arbiter with a RAM model, plus a 4-master round-robin one.
module tb_mem_port_arbiter;

    typedef struct {
        bit          rv;
        int          m;
        bit          w;
        logic [11:0] addr;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    ev_t qa[$];
    ev_t qb[$];
    ev_t ea, eb;
    logic [31:0] model [logic [11:0]];

    // 2-master fixed-priority instance
    logic        rst_a;
    logic [1:0]  a_req, a_we, a_lock, a_gnt, a_rvalid;
    logic [23:0] a_addr;
    logic [63:0] a_wdata;
    logic [31:0] a_rdata, a_ram_wdata, a_ram_rdata;
    logic [0:0]  a_owner;
    logic        a_busy, a_ram_we, a_ram_re, a_ram_busy;
    logic [11:0] a_ram_addr;
    logic [31:0] ram_a [0:4095];

    mem_port_arbiter #(.NUM_MASTERS(2), .ADDR_W(12), .DATA_W(32), .RR_MODE(0)) u_a (
        .clk(clk), .reset(rst_a), .req(a_req), .we(a_we), .lock(a_lock),
        .addr(a_addr), .wdata(a_wdata), .gnt(a_gnt), .rvalid(a_rvalid),
        .rdata(a_rdata), .owner(a_owner), .busy(a_busy), .ram_we(a_ram_we),
        .ram_re(a_ram_re), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata), .ram_busy(a_ram_busy)
    );

    always @(posedge clk) begin
        if (a_ram_we) ram_a[a_ram_addr] <= a_ram_wdata;
        if (a_ram_re) a_ram_rdata <= ram_a[a_ram_addr];
    end

    // 4-master round-robin instance; its RAM returns a fixed function of the address
    logic         rst_b;
    logic [3:0]   b_req, b_we, b_lock, b_gnt, b_rvalid;
    logic [47:0]  b_addr;
    logic [127:0] b_wdata;
    logic [31:0]  b_rdata, b_ram_wdata, b_ram_rdata;
    logic [1:0]   b_owner;
    logic         b_busy, b_ram_we, b_ram_re, b_ram_busy;
    logic [11:0]  b_ram_addr;

    mem_port_arbiter #(.NUM_MASTERS(4), .ADDR_W(12), .DATA_W(32), .RR_MODE(1)) u_b (
        .clk(clk), .reset(rst_b), .req(b_req), .we(b_we), .lock(b_lock),
        .addr(b_addr), .wdata(b_wdata), .gnt(b_gnt), .rvalid(b_rvalid),
        .rdata(b_rdata), .owner(b_owner), .busy(b_busy), .ram_we(b_ram_we),
        .ram_re(b_ram_re), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .ram_busy(b_ram_busy)
    );

    always @(posedge clk) begin
        if (b_ram_re) b_ram_rdata <= 32'hC000_0000 | {20'd0, b_ram_addr};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input int m, input bit w, input logic [11:0] ad, input logic [31:0] d);
        ev_t e;
        e.rv = 1'b0; e.m = m; e.w = w; e.addr = ad; e.data = d;
        qa.push_back(e);
        if (w) model[ad] = d;
        else begin
            e.rv = 1'b1; e.data = model[ad];
            qa.push_back(e);
        end
    endtask

    task automatic a_acc(input int m, input bit w, input logic [11:0] ad, input logic [31:0] d);
        int n;
        a_req[m] = 1'b1; a_we[m] = w; a_addr[m*12 +: 12] = ad; a_wdata[m*32 +: 32] = d;
        exp_a(m, w, ad, d);
        n = 0;
        do begin @(negedge clk); n++; end while (!a_gnt[m] && n < 20);
        chk("a_gnt_latency", n, 2);
        nxt();
        a_req[m] = 1'b0;
        if (!w) begin
            @(negedge clk);
            chk("a_rvalid_timing", a_rvalid[m], 1);
        end
        nxt();
    endtask

    task automatic wait_gnt_a();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (a_gnt == 2'b00 && n < 20);
        chk("a_gnt_seen", |a_gnt, 1);
    endtask

    // Scoreboard monitors: every gnt/rvalid must match the next expected event
    always @(negedge clk) begin
        if (!rst_a) begin
            chk("a_gnt_onehot", $onehot0(a_gnt), 1);
            chk("a_we_re_excl", a_ram_we & a_ram_re, 0);
            for (int m = 0; m < 2; m++) begin
                if (a_gnt[m] || a_rvalid[m]) begin
                    if (qa.size() == 0) chk("a_unexpected_event", m, 99);
                    else begin
                        ea = qa.pop_front();
                        chk("a_event_kind", a_rvalid[m], ea.rv);
                        chk("a_event_master", m, ea.m);
                        if (a_gnt[m]) begin
                            chk("a_ram_addr", a_ram_addr, ea.addr);
                            chk("a_ram_we", a_ram_we, ea.w);
                            chk("a_ram_re", a_ram_re, !ea.w);
                            if (ea.w) chk("a_ram_wdata", a_ram_wdata, ea.data);
                        end else chk("a_rdata", a_rdata, ea.data);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            chk("b_gnt_onehot", $onehot0(b_gnt), 1);
            for (int m = 0; m < 4; m++) begin
                if (b_gnt[m] || b_rvalid[m]) begin
                    if (qb.size() == 0) chk("b_unexpected_event", m, 99);
                    else begin
                        eb = qb.pop_front();
                        chk("b_event_kind", b_rvalid[m], eb.rv);
                        chk("b_event_master", m, eb.m);
                        if (b_gnt[m]) chk("b_ram_addr", b_ram_addr, eb.addr);
                        else          chk("b_rdata", b_rdata, eb.data);
                    end
                end
            end
        end
    end

    initial begin
        ev_t e;
        int  cnt;
        rst_a = 1'b1; rst_b = 1'b1;
        a_req = '0; a_we = '0; a_lock = '0; a_addr = '0; a_wdata = '0; a_ram_busy = 1'b0;
        b_req = '0; b_we = '0; b_lock = '0; b_addr = '0; b_wdata = '0; b_ram_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", a_gnt, 0);
        chk("rst_rvalid", a_rvalid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ram_we", a_ram_we, 0);
        chk("rst_ram_re", a_ram_re, 0);
        chk("rst_ram_addr", a_ram_addr, 0);
        chk("rst_ram_wdata", a_ram_wdata, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_owner", a_owner, 0);
        chk("rst_b_busy", b_busy, 0);
        nxt();
        rst_a = 1'b0; rst_b = 1'b0;
        nxt();

        // single write, then read-back
        a_acc(1, 1'b1, 12'h010, 32'hDEADBEEF);
        a_acc(1, 1'b0, 12'h010, 32'h0);
        @(negedge clk);
        chk("rdata_hold", a_rdata, 32'hDEADBEEF);
        nxt();

        // fixed priority: master 0 keeps winning while both request
        a_req = 2'b11; a_we = 2'b11;
        a_addr = {12'h200, 12'h100}; a_wdata = {32'h2222_0000, 32'h1111_0000};
        exp_a(0, 1'b1, 12'h100, 32'h1111_0000);
        for (int k = 0; k < 3; k++) begin
            wait_gnt_a();
            chk("fix_gnt_m0", a_gnt, 2'b01);
            nxt();
            if (k < 2) begin
                a_addr[11:0] = 12'h101 + 12'(k); a_wdata[31:0] = 32'h1111_0001 + k;
                exp_a(0, 1'b1, 12'h101 + 12'(k), 32'h1111_0001 + k);
            end else begin
                a_req[0] = 1'b0;
                exp_a(1, 1'b1, 12'h200, 32'h2222_0000);
            end
        end
        wait_gnt_a();
        chk("fix_gnt_m1", a_gnt, 2'b10);
        nxt();
        a_req = 2'b00;
        nxt();

        // locked burst of 4 writes from master 0, ram_busy stall mid-burst
        a_req = 2'b11; a_we = 2'b11; a_lock = 2'b01;
        a_addr = {12'h300, 12'h000}; a_wdata = {32'h0000_1111, 32'h0000_0050};
        exp_a(0, 1'b1, 12'h000, 32'h50);
        @(negedge clk); chk("burst_c0_idle", a_gnt, 2'b00);
        nxt();
        @(negedge clk); chk("burst_c1", a_gnt, 2'b01);
        nxt(); a_addr[11:0] = 12'h001; a_wdata[31:0] = 32'h51; exp_a(0, 1'b1, 12'h001, 32'h51);
        @(negedge clk); chk("burst_c2", a_gnt, 2'b01);
        nxt(); a_addr[11:0] = 12'h002; a_wdata[31:0] = 32'h52; exp_a(0, 1'b1, 12'h002, 32'h52);
        a_ram_busy = 1'b1;
        @(negedge clk); chk("burst_stall1_gnt", a_gnt, 2'b00); chk("burst_stall1_we", a_ram_we, 0);
        nxt();
        @(negedge clk); chk("burst_stall2_gnt", a_gnt, 2'b00); chk("burst_stall2_busy", a_busy, 1);
        nxt(); a_ram_busy = 1'b0;
        @(negedge clk); chk("burst_c5", a_gnt, 2'b01);
        nxt(); a_addr[11:0] = 12'h003; a_wdata[31:0] = 32'h53; a_lock = 2'b00;
        exp_a(0, 1'b1, 12'h003, 32'h53);
        @(negedge clk); chk("burst_c6", a_gnt, 2'b01);
        nxt(); a_req[0] = 1'b0; exp_a(1, 1'b1, 12'h300, 32'h0000_1111);
        @(negedge clk); chk("burst_c7_idle", a_gnt, 2'b00);
        nxt();
        @(negedge clk); chk("burst_c8_m1", a_gnt, 2'b10);
        nxt(); a_req = 2'b00;
        nxt();

        // reset while a read sits in ISSUE
        a_req[1] = 1'b1; a_we[1] = 1'b0; a_addr[23:12] = 12'h002;
        @(negedge clk); chk("rstmid_idle", a_gnt, 2'b00);
        nxt();
        rst_a = 1'b1;
        @(negedge clk);
        chk("rstmid_gnt", a_gnt, 0);
        chk("rstmid_ram_re", a_ram_re, 0);
        chk("rstmid_busy", a_busy, 0);
        chk("rstmid_owner", a_owner, 0);
        chk("rstmid_rdata", a_rdata, 0);
        chk("rstmid_addr", a_ram_addr, 0);
        nxt(); a_req = 2'b00;
        @(negedge clk); chk("rstmid_rvalid", a_rvalid, 0);
        nxt(); rst_a = 1'b0;
        nxt();
        a_acc(1, 1'b0, 12'h010, 32'h0);

        // round-robin, 4 masters all reading continuously
        for (int k = 0; k < 5; k++) begin
            e.rv = 1'b0; e.m = k % 4; e.w = 1'b0; e.addr = 12'h040 + 12'(k % 4); e.data = 32'h0;
            qb.push_back(e);
            e.rv = 1'b1; e.data = 32'hC000_0040 + (k % 4);
            qb.push_back(e);
        end
        b_addr = {12'h043, 12'h042, 12'h041, 12'h040};
        b_we = 4'h0; b_req = 4'hF;
        cnt = 0;
        for (int n = 0; n < 60 && cnt < 5; n++) begin
            @(negedge clk);
            if (|b_gnt) cnt++;
        end
        chk("rr_five_gnts", cnt, 5);
        nxt(); b_req = 4'h0;
        repeat (4) @(negedge clk);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
